// File: rtl/hazard_pkg.sv
// Shared constants and types for the PMIPS hazard unit: opcodes, instruction
// field positions, forward-select encodings and the scoreboard entry layout.
package hazard_pkg;

  localparam int unsigned OP_W      = 4;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned RS_LSB    = 9;
  localparam int unsigned RT_LSB    = 6;
  localparam int unsigned RD_LSB    = 3;
  localparam int unsigned FWD_W     = 2;
  // Scoreboard dest field is sized for the widest register index we support
  localparam int unsigned SB_DEST_W = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 4'h0;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL   = 4'h2;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'h4;
  localparam logic [OP_W-1:0] OP_LW    = 4'h8;
  localparam logic [OP_W-1:0] OP_SW    = 4'hA;
  localparam logic [OP_W-1:0] OP_J     = 4'hF;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_if.sv
// ID-stage hazard interface: instruction in, stall and forward selects out.
interface hazard_if
  import hazard_pkg::*;
#(
  parameter int unsigned INSTR_W = 16
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               flush;
  logic               stall;
  logic [FWD_W-1:0]   fwd_a;
  logic [FWD_W-1:0]   fwd_b;

  modport master (output instr_valid, instr, flush, input stall, fwd_a, fwd_b);
  modport slave  (input instr_valid, instr, flush, output stall, fwd_a, fwd_b);
endinterface

// File: rtl/hazard_decode.sv
// Combinational decode of register reads, writes and hazard class for one
// PMIPS instruction.
module hazard_decode
  import hazard_pkg::*;
#(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic [INSTR_W-1:0]    instr,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  uses_rs,
  output logic                  uses_rt,
  output logic                  writes,
  output logic                  is_load,
  output logic                  is_mul
);
  logic [OP_W-1:0]       op;
  logic [REG_ADDR_W-1:0] rd;
  logic                  unused_low_bits;

  assign op = instr[OP_LSB +: OP_W];
  assign rs = instr[RS_LSB +: REG_ADDR_W];
  assign rt = instr[RT_LSB +: REG_ADDR_W];
  assign rd = instr[RD_LSB +: REG_ADDR_W];
  assign unused_low_bits = ^instr[RD_LSB-1:0];

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    writes  = 1'b0;
    dest    = rd;
    is_load = 1'b0;
    is_mul  = 1'b0;
    case (op)
      OP_RTYPE, OP_MUL: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        writes  = 1'b1;
        is_mul  = (op == OP_MUL);
      end
      OP_ADDI, OP_LW: begin
        uses_rs = 1'b1;
        writes  = 1'b1;
        dest    = rt;
        is_load = (op == OP_LW);
      end
      OP_SW, OP_BEQ: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J:    ;
      default: ;
    endcase
  end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: scoreboard of in-flight writes, multiply busy counter,
// stall and forward-select generation. HAZARD_FWD_EN compiles in forwarding.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned MUL_LAT    = 4
) (
  input logic     clock,
  input logic     reset_n,
  hazard_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  logic [REG_ADDR_W-1:0] rs, rt, dest;
  logic                  uses_rs, uses_rt, writes, is_load, is_mul;
  sb_entry_t             sb [DEPTH];
  sb_entry_t             new_entry;
  logic [CNT_W-1:0]      mul_cnt;
  logic                  issue, data_stall, mul_stall, stall_c;

  hazard_decode #(.INSTR_W(INSTR_W), .REG_ADDR_W(REG_ADDR_W)) u_decode (
    .instr   (bus.instr),
    .rs      (rs),
    .rt      (rt),
    .dest    (dest),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt),
    .writes  (writes),
    .is_load (is_load),
    .is_mul  (is_mul)
  );

  // Register 0 never matches, so neither a zero source nor a zero dest creates a hazard
  function automatic logic hit(input logic used, input logic [REG_ADDR_W-1:0] src,
                               input sb_entry_t e);
    return used && (src != '0) && e.valid && (e.dest == SB_DEST_W'(src));
  endfunction

  assign mul_stall = (mul_cnt != '0);
  assign stall_c   = bus.instr_valid & ~bus.flush & (data_stall | mul_stall);
  assign issue     = bus.instr_valid & ~stall_c & ~bus.flush;
  assign bus.stall = stall_c;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = issue & writes;
    new_entry.dest  = SB_DEST_W'(dest);
`ifdef HAZARD_FWD_EN
    new_entry.is_load = is_load;
`endif
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    data_stall = (hit(uses_rs, rs, sb[0]) | hit(uses_rt, rt, sb[0])) & sb[0].is_load;
  end

  // EX has priority over MEM; a stalled instruction's selects are don't-care, forced to RF
  always_comb begin
    bus.fwd_a = FWD_RF;
    bus.fwd_b = FWD_RF;
    if (!stall_c) begin
      if (hit(uses_rs, rs, sb[0]) && !sb[0].is_load) bus.fwd_a = FWD_EX;
      else if (hit(uses_rs, rs, sb[1]))              bus.fwd_a = FWD_MEM;
      if (hit(uses_rt, rt, sb[0]) && !sb[0].is_load) bus.fwd_b = FWD_EX;
      else if (hit(uses_rt, rt, sb[1]))              bus.fwd_b = FWD_MEM;
    end
  end
`else
  logic unused_is_load;
  assign unused_is_load = is_load;

  // WB entry is excluded: the register file writes before it reads
  always_comb begin
    data_stall = 1'b0;
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      if (hit(uses_rs, rs, sb[k]) || hit(uses_rt, rt, sb[k])) data_stall = 1'b1;
    end
  end

  assign bus.fwd_a = FWD_RF;
  assign bus.fwd_b = FWD_RF;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(DEPTH); k++) sb[k] <= '0;
      mul_cnt <= '0;
    end else begin
      sb[0] <= new_entry;
      for (int k = 1; k < int'(DEPTH); k++) sb[k] <= sb[k-1];
      if (issue && is_mul)    mul_cnt <= CNT_W'(MUL_LAT - 1);
      else if (mul_cnt != '0) mul_cnt <= mul_cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, reset corners and
// random stimulus against an issue-log reference model. Honours HAZARD_FWD_EN.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int DEPTH   = 3;
  localparam int MUL_LAT = 4;
  localparam int NEVER   = -1000;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  hazard_if #(.INSTR_W(16)) bus ();

  hazard_unit #(.INSTR_W(16), .REG_ADDR_W(3), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a log of issued register writes keyed by issue cycle
  typedef struct {int c; int dest; bit ld;} wr_t;
  wr_t wlog[$];
  int  cyc      = 0;
  int  last_mul = NEVER;
  bit  m_st;
  int  m_fa, m_fb;

  typedef struct {bit v; logic [15:0] i; bit f; bit st; int fa; int fb; string nm;} vec_t;
  vec_t tbl[$];

  function automatic logic [15:0] rt3(input int op, input int s, input int t, input int d);
    return {4'(op), 3'(s), 3'(t), 3'(d), 3'b000};
  endfunction

  function automatic logic [15:0] itp(input int op, input int s, input int t, input int imm);
    return {4'(op), 3'(s), 3'(t), 6'(imm)};
  endfunction

  function automatic void add(input bit v, input logic [15:0] i, input bit f,
                              input bit st, input int fa, input int fb, input string nm);
    vec_t e;
    e.v = v; e.i = i; e.f = f; e.st = st; e.fa = fa; e.fb = fb; e.nm = nm;
    tbl.push_back(e);
  endfunction

  function automatic void idles(input int n);
    for (int k = 0; k < n; k++) add(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, "idle");
  endfunction

  function automatic void m_decode(input logic [15:0] i, output bit urs, output bit urt,
                                   output bit wr, output bit ld, output bit mul,
                                   output int rs, output int rt, output int dst);
    int op;
    op = int'(i[15:12]); rs = int'(i[11:9]); rt = int'(i[8:6]);
    urs = 0; urt = 0; wr = 0; ld = 0; mul = 0; dst = 0;
    if (op == 0 || op == 2) begin urs = 1; urt = 1; wr = 1; dst = int'(i[5:3]); mul = (op == 2); end
    else if (op == 1 || op == 8) begin urs = 1; wr = 1; dst = rt; ld = (op == 8); end
    else if (op == 'hA || op == 4) begin urs = 1; urt = 1; end
  endfunction

  // Was register r written by the instruction issued d cycles ago?
  function automatic bit wr_at(input int r, input int d, output bit ld);
    ld = 0;
    if (r == 0) return 0;
    foreach (wlog[k]) if (wlog[k].c == cyc - d && wlog[k].dest == r) begin ld = wlog[k].ld; return 1; end
    return 0;
  endfunction

  function automatic bit raw(input bit u, input int r, input bit fwd_mode);
    bit ld;
    if (!u) return 0;
    if (fwd_mode) return wr_at(r, 1, ld) && ld;
    for (int d = 1; d <= DEPTH - 1; d++) if (wr_at(r, d, ld)) return 1;
    return 0;
  endfunction

  function automatic int sel(input bit u, input int r);
    bit ld;
    if (!u) return 0;
    if (wr_at(r, 1, ld) && !ld) return 1;
    if (wr_at(r, 2, ld)) return 2;
    return 0;
  endfunction

  function automatic void model_eval(input bit v, input logic [15:0] i, input bit f);
    bit urs, urt, wr, ld, mul, fwd_mode, data;
    int rs, rt, dst;
`ifdef HAZARD_FWD_EN
    fwd_mode = 1;
`else
    fwd_mode = 0;
`endif
    m_decode(i, urs, urt, wr, ld, mul, rs, rt, dst);
    data = raw(urs, rs, fwd_mode) || raw(urt, rt, fwd_mode);
    m_st = v && !f && (data || (cyc - last_mul) < MUL_LAT);
    m_fa = 0; m_fb = 0;
    if (fwd_mode && !m_st) begin m_fa = sel(urs, rs); m_fb = sel(urt, rt); end
  endfunction

  function automatic void model_commit(input bit v, input logic [15:0] i, input bit f);
    bit urs, urt, wr, ld, mul;
    int rs, rt, dst;
    wr_t e;
    m_decode(i, urs, urt, wr, ld, mul, rs, rt, dst);
    if (v && !f && !m_st) begin
      if (wr && dst != 0) begin e.c = cyc; e.dest = dst; e.ld = ld; wlog.push_back(e); end
      if (mul) last_mul = cyc;
    end
    cyc++;
    while (wlog.size() > 0 && wlog[0].c < cyc - 8) void'(wlog.pop_front());
  endfunction

  function automatic void model_reset();
    wlog.delete();
    last_mul = NEVER;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, compare 1 ns later, advance the model at posedge
  task automatic cycle(input bit v, input logic [15:0] i, input bit f, input bit use_tbl,
                       input bit st, input int fa, input int fb, input string nm);
    @(negedge clock);
    bus.instr_valid = v; bus.instr = i; bus.flush = f;
    #1;
    model_eval(v, i, f);
    if (use_tbl) begin
      chk({nm, "_stall"}, int'(bus.stall), int'(st));
      chk({nm, "_fwd_a"}, int'(bus.fwd_a), fa);
      chk({nm, "_fwd_b"}, int'(bus.fwd_b), fb);
    end else begin
      chk({nm, "_stall"}, int'(bus.stall), int'(m_st));
      chk({nm, "_fwd_a"}, int'(bus.fwd_a), m_fa);
      chk({nm, "_fwd_b"}, int'(bus.fwd_b), m_fb);
    end
    @(posedge clock);
    if (reset_n) model_commit(v, i, f);
  endtask

  initial begin
    logic [15:0] add1, sub1, lw, add2, mul, addi, ri;
    logic [3:0]  ops [8];
    bit          rv, rf;

    add1 = rt3(0, 1, 1, 3);  sub1 = rt3(0, 3, 3, 5);
    lw   = itp(8, 1, 2, 0);  add2 = rt3(0, 2, 4, 3);
    mul  = rt3(2, 1, 2, 4);  addi = itp(1, 5, 6, 1);

`ifdef HAZARD_FWD_EN
    add(1, add1, 0, 0, 0, 0, "addsub_p"); add(1, sub1, 0, 0, 1, 1, "addsub_ex");
    idles(4);
    add(1, lw, 0, 0, 0, 0, "lu_p"); add(1, add2, 0, 1, 0, 0, "lu_stall");
    add(1, add2, 0, 0, 2, 0, "lu_mem");
    idles(4);
    add(1, add1, 0, 0, 0, 0, "mem_p"); idles(1); add(1, sub1, 0, 0, 2, 2, "mem_fwd");
`else
    add(1, add1, 0, 0, 0, 0, "addsub_p"); add(1, sub1, 0, 1, 0, 0, "addsub_st1");
    add(1, sub1, 0, 1, 0, 0, "addsub_st2"); add(1, sub1, 0, 0, 0, 0, "addsub_go");
    idles(4);
    add(1, lw, 0, 0, 0, 0, "lu_p"); add(1, add2, 0, 1, 0, 0, "lu_st1");
    add(1, add2, 0, 1, 0, 0, "lu_st2"); add(1, add2, 0, 0, 0, 0, "lu_go");
    idles(4);
    add(1, add1, 0, 0, 0, 0, "mem_p"); idles(1); add(1, sub1, 0, 1, 0, 0, "mem_st");
    add(1, sub1, 0, 0, 0, 0, "mem_go");
`endif
    idles(4);
    add(1, add1, 0, 0, 0, 0, "wb_p"); idles(2); add(1, sub1, 0, 0, 0, 0, "wb_excl");
    idles(4);
    add(1, mul, 0, 0, 0, 0, "mul_p");
    for (int k = 0; k < MUL_LAT - 1; k++) add(1, addi, 0, 1, 0, 0, "mul_stall");
    add(1, addi, 0, 0, 0, 0, "mul_done");
    idles(4);
    add(1, rt3(0, 1, 1, 0), 0, 0, 0, 0, "r0_p"); add(1, rt3(0, 0, 0, 2), 0, 0, 0, 0, "r0_c");
    idles(4);
    add(1, lw, 0, 0, 0, 0, "fl_p"); add(1, add2, 1, 0, 0, 0, "flush_kill");
    add(1, sub1, 0, 0, 0, 0, "flush_bubble");
    idles(4);
    add(1, lw, 0, 0, 0, 0, "inv_p"); add(0, add2, 0, 0, 0, 0, "invalid");
`ifdef HAZARD_FWD_EN
    add(1, add2, 0, 0, 2, 0, "inv_mem");
`else
    add(1, add2, 0, 1, 0, 0, "inv_st"); add(1, add2, 0, 0, 0, 0, "inv_go");
`endif
    idles(4);
    add(1, lw, 0, 0, 0, 0, "j_p"); add(1, itp(15, 2, 2, 0), 0, 0, 0, 0, "j_noread");
    idles(4);

    // Reset held with a live load in ID
    reset_n = 1'b1;
    bus.instr_valid = 1'b1; bus.instr = lw; bus.flush = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    cycle(1, lw, 0, 1, 0, 0, 0, "rst_hold0");
    cycle(1, add2, 0, 1, 0, 0, 0, "rst_hold1");
    reset_n = 1'b1;

    foreach (tbl[k]) cycle(tbl[k].v, tbl[k].i, tbl[k].f, 1, tbl[k].st, tbl[k].fa, tbl[k].fb, tbl[k].nm);

    // Reset asserted in the middle of a multiply stall
    cycle(1, mul, 0, 1, 0, 0, 0, "rm_mul");
    cycle(1, addi, 0, 1, 1, 0, 0, "rm_stall");
    @(negedge clock);
    bus.instr_valid = 1'b1; bus.instr = addi; bus.flush = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rm_async_stall", int'(bus.stall), 0);
    model_reset();
    @(negedge clock);
    bus.instr_valid = 1'b0;
    reset_n = 1'b1;
    cycle(1, addi, 0, 1, 0, 0, 0, "rm_after");

    ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hA, 4'hF, 4'h3};
    ri = 16'h0000; rv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!(m_st && $urandom_range(0, 3) != 0)) begin
        rv = ($urandom_range(0, 9) != 0);
        ri = {ops[$urandom_range(0, 7)], 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
              3'($urandom_range(0, 4)), 3'($urandom)};
      end
      rf = ($urandom_range(0, 15) == 0);
      cycle(rv, ri, rf, 0, 0, 0, 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
